// File: rtl/game_ram.sv
// game_ram: 4096x32 word-addressed data memory for the space-invaders CPU,
// with a memory-mapped I/O window at 0x100-0x13F. Game-state registers in
// the window feed the VGA and seven-segment logic directly; button levels
// are readable as status words.
module game_ram #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 12,
  parameter int LIVES_INIT    = 3,
  parameter int PLAYER_X_INIT = 320,
  parameter int PLAYER_Y_INIT = 440
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wEn,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic [DATA_WIDTH-1:0] sprite1X,
  output logic [DATA_WIDTH-1:0] sprite2X,
  output logic [DATA_WIDTH-1:0] sprite3X,
  output logic [DATA_WIDTH-1:0] sprite4X,
  output logic [DATA_WIDTH-1:0] sprite5X,
  output logic [DATA_WIDTH-1:0] sprite6X,
  output logic [DATA_WIDTH-1:0] sprite7X,
  output logic [DATA_WIDTH-1:0] sprite8X,
  output logic [DATA_WIDTH-1:0] sprite9X,
  output logic [DATA_WIDTH-1:0] sprite10X,
  output logic [DATA_WIDTH-1:0] sprite1Y,
  output logic [DATA_WIDTH-1:0] sprite2Y,
  output logic [DATA_WIDTH-1:0] sprite3Y,
  output logic [DATA_WIDTH-1:0] sprite4Y,
  output logic [DATA_WIDTH-1:0] sprite5Y,
  output logic [DATA_WIDTH-1:0] sprite6Y,
  output logic [DATA_WIDTH-1:0] sprite7Y,
  output logic [DATA_WIDTH-1:0] sprite8Y,
  output logic [DATA_WIDTH-1:0] sprite9Y,
  output logic [DATA_WIDTH-1:0] sprite10Y,
  output logic [DATA_WIDTH-1:0] laser,
  output logic [DATA_WIDTH-1:0] playerLives,
  output logic [DATA_WIDTH-1:0] playerScore,
  output logic [DATA_WIDTH-1:0] playerX,
  output logic [DATA_WIDTH-1:0] playerY,
  input  logic                  moveRight,
  input  logic                  moveLeft,
  input  logic                  laserOn
);

  localparam logic [ADDR_WIDTH-1:0] IO_LO = ADDR_WIDTH'('h100);
  localparam logic [ADDR_WIDTH-1:0] IO_HI = ADDR_WIDTH'('h13F);

  // Array words inside the I/O window are never touched; the waste keeps the
  // decode trivial. Contents start at zero and survive reset.
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH] = '{default: '0};

  logic [DATA_WIDTH-1:0] spriteX [10];
  logic [DATA_WIDTH-1:0] spriteY [10];
  logic [DATA_WIDTH-1:0] rdData;
  logic                  isIo;
  logic [5:0]            ioOff;
  logic [3:0]            ioIdx;

  assign isIo  = (addr >= IO_LO) && (addr <= IO_HI);
  assign ioOff = addr[5:0];
  assign ioIdx = ioOff[3:0];

  assign sprite1X  = spriteX[0];
  assign sprite2X  = spriteX[1];
  assign sprite3X  = spriteX[2];
  assign sprite4X  = spriteX[3];
  assign sprite5X  = spriteX[4];
  assign sprite6X  = spriteX[5];
  assign sprite7X  = spriteX[6];
  assign sprite8X  = spriteX[7];
  assign sprite9X  = spriteX[8];
  assign sprite10X = spriteX[9];
  assign sprite1Y  = spriteY[0];
  assign sprite2Y  = spriteY[1];
  assign sprite3Y  = spriteY[2];
  assign sprite4Y  = spriteY[3];
  assign sprite5Y  = spriteY[4];
  assign sprite6Y  = spriteY[5];
  assign sprite7Y  = spriteY[6];
  assign sprite8Y  = spriteY[7];
  assign sprite9Y  = spriteY[8];
  assign sprite10Y = spriteY[9];

  // Read mux: array word, mapped register, button level, or zero for unused I/O.
  always_comb begin
    rdData = '0;
    if (!isIo) begin
      rdData = mem[addr];
    end else if (ioOff[5:4] == 2'b00) begin
      if (ioIdx < 4'd10) rdData = spriteX[ioIdx];
    end else if (ioOff[5:4] == 2'b01) begin
      if (ioIdx < 4'd10) rdData = spriteY[ioIdx];
    end else if (ioOff[5:4] == 2'b10) begin
      case (ioIdx)
        4'd0:    rdData = laser;
        4'd1:    rdData = playerLives;
        4'd2:    rdData = playerScore;
        4'd3:    rdData = playerX;
        4'd4:    rdData = playerY;
        default: rdData = '0;
      endcase
    end else begin
      case (ioIdx)
        4'd0:    rdData = {{(DATA_WIDTH-1){1'b0}}, moveRight};
        4'd1:    rdData = {{(DATA_WIDTH-1){1'b0}}, moveLeft};
        4'd2:    rdData = {{(DATA_WIDTH-1){1'b0}}, laserOn};
        default: rdData = '0;
      endcase
    end
  end

  // Registered read port; the mux sees pre-write state, giving read-before-write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dataOut <= '0;
    else        dataOut <= rdData;
  end

  // Array write; reset is sampled here so writes during reset are dropped
  // while stored words are left intact.
  always_ff @(posedge clk) begin
    if (reset && wEn && !isIo) mem[addr] <= dataIn;
  end

  // Mapped game-state registers; button and unused offsets ignore writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 10; i++) begin
        spriteX[i] <= '0;
        spriteY[i] <= '0;
      end
      laser       <= '0;
      playerLives <= DATA_WIDTH'(LIVES_INIT);
      playerScore <= '0;
      playerX     <= DATA_WIDTH'(PLAYER_X_INIT);
      playerY     <= DATA_WIDTH'(PLAYER_Y_INIT);
    end else if (wEn && isIo) begin
      if (ioOff[5:4] == 2'b00) begin
        if (ioIdx < 4'd10) spriteX[ioIdx] <= dataIn;
      end else if (ioOff[5:4] == 2'b01) begin
        if (ioIdx < 4'd10) spriteY[ioIdx] <= dataIn;
      end else if (ioOff[5:4] == 2'b10) begin
        case (ioIdx)
          4'd0:    laser       <= dataIn;
          4'd1:    playerLives <= dataIn;
          4'd2:    playerScore <= dataIn;
          4'd3:    playerX     <= dataIn;
          4'd4:    playerY     <= dataIn;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_ram.sv
// tb_game_ram: directed vectors for game_ram. Expected read data is queued
// when a read is issued; a monitor pops and compares one cycle later.
module tb_game_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        wEn;
  logic [11:0] addr;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic [31:0] sX [10];
  logic [31:0] sY [10];
  logic [31:0] laser, playerLives, playerScore, playerX, playerY;
  logic        moveRight, moveLeft, laserOn;

  logic        chkReq = 1'b0;
  logic        pend   = 1'b0;
  int          total  = 0;
  int          bad    = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t expQ [$];

  always #5 clk = ~clk;

  game_ram dut (
    .clk(clk), .reset(reset), .wEn(wEn), .addr(addr), .dataIn(dataIn),
    .dataOut(dataOut),
    .sprite1X(sX[0]), .sprite2X(sX[1]), .sprite3X(sX[2]), .sprite4X(sX[3]),
    .sprite5X(sX[4]), .sprite6X(sX[5]), .sprite7X(sX[6]), .sprite8X(sX[7]),
    .sprite9X(sX[8]), .sprite10X(sX[9]),
    .sprite1Y(sY[0]), .sprite2Y(sY[1]), .sprite3Y(sY[2]), .sprite4Y(sY[3]),
    .sprite5Y(sY[4]), .sprite6Y(sY[5]), .sprite7Y(sY[6]), .sprite8Y(sY[7]),
    .sprite9Y(sY[8]), .sprite10Y(sY[9]),
    .laser(laser), .playerLives(playerLives), .playerScore(playerScore),
    .playerX(playerX), .playerY(playerY),
    .moveRight(moveRight), .moveLeft(moveLeft), .laserOn(laserOn)
  );

  // Monitor: a checked read issued at an edge shows on dataOut after it.
  always @(posedge clk) pend <= chkReq;

  always @(negedge clk) begin
    if (pend) begin
      exp_t e;
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("FAIL %s: dataOut=%h but no expected value queued", "scoreboard", dataOut);
      end else begin
        e = expQ.pop_front();
        if (dataOut !== e.val) begin
          bad++;
          $display("FAIL %s: dataOut=%h expected=%h", e.name, dataOut, e.val);
        end
      end
    end
  end

  task automatic chkPort(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // One access: drive at negedge, let the posedge occur, return 1 after it.
  task automatic cyc(input logic w, input logic [11:0] a, input logic [31:0] d,
                     input logic chk, input logic [31:0] exp, input string name);
    @(negedge clk);
    wEn    = w;
    addr   = a;
    dataIn = d;
    chkReq = chk;
    if (chk) expQ.push_back('{name, exp});
    @(posedge clk);
    #1;
    wEn    = 1'b0;
    chkReq = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wEn = 1'b0; addr = '0; dataIn = '0;
    moveRight = 1'b0; moveLeft = 1'b0; laserOn = 1'b0;

    // Asynchronous reset before any clock edge
    #2 reset = 1'b0;
    #1;
    chkPort("rst_dataOut", dataOut, 32'd0);
    chkPort("rst_lives", playerLives, 32'd3);
    chkPort("rst_playerX", playerX, 32'd320);
    chkPort("rst_playerY", playerY, 32'd440);
    chkPort("rst_sprite1X", sX[0], 32'd0);
    chkPort("rst_sprite10Y", sY[9], 32'd0);
    chkPort("rst_laser", laser, 32'd0);
    chkPort("rst_score", playerScore, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // RAM write/read
    cyc(1'b1, 12'h005, 32'hDEADBEEF, 1'b0, 32'd0, "");
    cyc(1'b0, 12'h005, 32'd0, 1'b1, 32'hDEADBEEF, "ram_rd_005");
    cyc(1'b0, 12'h006, 32'd0, 1'b1, 32'd0, "ram_rd_006");

    // Mapped sprite writes
    cyc(1'b1, 12'h104, 32'd7, 1'b0, 32'd0, "");
    chkPort("sprite5X", sX[4], 32'd7);
    chkPort("sprite4X_unch", sX[3], 32'd0);
    chkPort("sprite6X_unch", sX[5], 32'd0);
    cyc(1'b1, 12'h114, 32'd200, 1'b0, 32'd0, "");
    chkPort("sprite5Y", sY[4], 32'd200);
    chkPort("sprite5X_hold", sX[4], 32'd7);
    chkPort("sprite4Y_unch", sY[3], 32'd0);
    cyc(1'b0, 12'h104, 32'd0, 1'b1, 32'd7, "map_rd_104");
    cyc(1'b0, 12'h114, 32'd0, 1'b1, 32'd200, "map_rd_114");
    cyc(1'b0, 12'h10A, 32'd0, 1'b1, 32'd0, "unused_rd_10A");

    // Buttons
    moveRight = 1'b1; moveLeft = 1'b0; laserOn = 1'b1;
    cyc(1'b0, 12'h130, 32'd0, 1'b1, 32'd1, "btn_right");
    cyc(1'b0, 12'h131, 32'd0, 1'b1, 32'd0, "btn_left");
    cyc(1'b0, 12'h132, 32'd0, 1'b1, 32'd1, "btn_laser");
    cyc(1'b1, 12'h130, 32'hFF, 1'b1, 32'd1, "btn_wr_ignored");
    moveRight = 1'b0; moveLeft = 1'b1;
    cyc(1'b0, 12'h130, 32'd0, 1'b1, 32'd0, "btn_right_follow");
    cyc(1'b0, 12'h131, 32'd0, 1'b1, 32'd1, "btn_left_follow");

    // Read-before-write on a mapped register and on the array
    cyc(1'b1, 12'h122, 32'd5, 1'b0, 32'd0, "");
    cyc(1'b1, 12'h122, 32'd9, 1'b1, 32'd5, "rbw_score");
    chkPort("score_after", playerScore, 32'd9);
    cyc(1'b0, 12'h122, 32'd0, 1'b1, 32'd9, "score_rd");
    cyc(1'b1, 12'h005, 32'h12345678, 1'b1, 32'hDEADBEEF, "rbw_ram");
    cyc(1'b0, 12'h005, 32'd0, 1'b1, 32'h12345678, "ram_rd_new");

    // Reset mid-run
    cyc(1'b1, 12'h121, 32'd1, 1'b0, 32'd0, "");
    chkPort("lives_wr", playerLives, 32'd1);
    cyc(1'b1, 12'h010, 32'd42, 1'b0, 32'd0, "");
    #2 reset = 1'b0;
    #1;
    chkPort("midrst_lives", playerLives, 32'd3);
    chkPort("midrst_sprite5X", sX[4], 32'd0);
    chkPort("midrst_score", playerScore, 32'd0);
    chkPort("midrst_dataOut", dataOut, 32'd0);
    wEn = 1'b1; addr = 12'h123; dataIn = 32'd99;
    @(posedge clk); #1;
    chkPort("rst_wr_map_ignored", playerX, 32'd320);
    chkPort("rst_dataOut_hold1", dataOut, 32'd0);
    addr = 12'h011; dataIn = 32'd77;
    @(posedge clk); #1;
    chkPort("rst_dataOut_hold2", dataOut, 32'd0);
    @(negedge clk);
    wEn = 1'b0;
    reset = 1'b1;
    cyc(1'b0, 12'h010, 32'd0, 1'b1, 32'd42, "ram_persist_010");
    cyc(1'b0, 12'h011, 32'd0, 1'b1, 32'd0, "rst_wr_ram_ignored");
    cyc(1'b0, 12'h123, 32'd0, 1'b1, 32'd320, "playerX_rd");
    cyc(1'b1, 12'h13F, 32'd123, 1'b0, 32'd0, "");
    cyc(1'b0, 12'h13F, 32'd0, 1'b1, 32'd0, "unused_13F");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_ram.md
# game_ram

Word-addressed 4096×32 data memory for the space-invaders processor, with an embedded memory-mapped I/O window. Game state written by the CPU (sprite positions, laser, lives, score, player position) drives dedicated output ports to the VGA controller and seven-segment logic. Debounced button inputs are readable by the CPU as status words. The block sits between the CPU data port and the display logic.

## Interface
- DATA_WIDTH, 32: word width of memory, dataIn/dataOut and all game-state ports.
- ADDR_WIDTH, 12: word address width; depth is 2^ADDR_WIDTH.
- LIVES_INIT, 3: reset value of playerLives.
- PLAYER_X_INIT, 320: reset value of playerX.
- PLAYER_Y_INIT, 440: reset value of playerY.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wEn  in  1  write enable for addr/dataIn.
- addr  in  ADDR_WIDTH  word address.
- dataIn  in  DATA_WIDTH  write data.
- dataOut  out  DATA_WIDTH  registered read data.
- sprite1X..sprite10X  out  DATA_WIDTH each  enemy sprite X positions.
- sprite1Y..sprite10Y  out  DATA_WIDTH each  enemy sprite Y positions.
- laser  out  DATA_WIDTH  laser state word.
- playerLives  out  DATA_WIDTH  remaining lives.
- playerScore  out  DATA_WIDTH  score.
- playerX, playerY  out  DATA_WIDTH each  player position.
- moveRight, moveLeft, laserOn  in  1 each  debounced button levels.

## Operation
- Address map (word addresses):
  - 0x100–0x109: sprite1X..sprite10X (R/W).
  - 0x110–0x119: sprite1Y..sprite10Y (R/W).
  - 0x120 laser, 0x121 playerLives, 0x122 playerScore, 0x123 playerX, 0x124 playerY (R/W).
  - 0x130 moveRight, 0x131 moveLeft, 0x132 laserOn (read-only; read as {31'b0, input}).
  - Remaining addresses in 0x100–0x13F: unused I/O; read 0, writes ignored.
  - All other addresses: plain RAM array.
- Mapped registers (0x100–0x124) are held in dedicated flops, not in the array. Each drives its output port directly, at full 32-bit width.
- Write (wEn=1) to a RAM address stores dataIn in the array. Write to an R/W mapped address loads the register. Write to a read-only or unused I/O address has no effect.
- Read: every edge, dataOut loads the word selected by addr, regardless of wEn. For button addresses, the input level is sampled at that edge.
- Same-address read and write in one cycle: dataOut returns the pre-write value (read-before-write), for both array and mapped registers.
- RAM array contents initialise to zero at configuration. Array contents are not affected by reset.

## Timing
- Reset asserted (reset=0), immediately and independent of clk:
  - dataOut=0.
  - All sprite X/Y = 0, laser=0, playerScore=0.
  - playerLives=LIVES_INIT, playerX=PLAYER_X_INIT, playerY=PLAYER_Y_INIT.
- While reset=0, writes are ignored and dataOut stays 0.
- Deassertion: the first rising edge with reset=1 performs normal access.
- Reset asserted mid-operation: a write pending at that edge is discarded. Mapped registers return to their reset values. Array words already written persist.
- Write latency: the mapped output port reflects the new value immediately after the write edge. The array word is readable by a read issued at the following edge.
- Read latency: 1 cycle. dataOut is valid after the edge at which addr was presented, and holds until the next edge.
- Button inputs are sampled only at a read edge. No internal synchronizer: inputs are assumed stable relative to clk (already debounced upstream).
- No handshake; one access per cycle.

## Test plan
- Reset: pulse reset=0 asynchronously between edges -> dataOut=0, playerLives=3, playerX=320, playerY=440, all sprites, laser and score 0, without any clk edge.
- RAM write/read: write 0xDEADBEEF to 0x005, then read 0x005 -> dataOut=0xDEADBEEF one cycle after the read edge. Read 0x006 -> 0.
- Mapped write: write 7 to 0x104 and 200 to 0x114 -> sprite5X=7 and sprite5Y=200 after the write edge. Read 0x104 -> 7. All other sprite ports unchanged.
- Buttons: moveRight=1, moveLeft=0, laserOn=1; read 0x130, 0x131, 0x132 -> 1, 0, 1. Write 0xFF to 0x130 -> no effect; subsequent read still follows the input.
- Read-before-write: with 0x122=5, write 9 to 0x122 while reading 0x122 -> dataOut=5 that cycle, playerScore=9. Next read returns 9.
- Reset mid-run: write playerLives=1 and RAM[0x010]=42, then assert reset -> playerLives=3. After release, reading 0x010 returns 42. Write to unused 0x13F then read it -> 0.
